// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: default data width, destination source
// indices and the skid-buffer occupancy encoding.
package cpu_pkg;

    localparam int unsigned DATA_W = 16;

    localparam int unsigned DST_A = 0;
    localparam int unsigned DST_B = 1;
    localparam int unsigned DST_C = 2;
    localparam int unsigned DST_D = 3;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_e;

endpackage

// File: rtl/dst_mux_pipe_if.sv
// Source-select / write-port bus of the destination mux pipe.
interface dst_mux_pipe_if
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH   = DATA_W,
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned SEL_W   = $clog2(NUM_SRC),
    parameter int unsigned CNT_W   = 16
);

    logic [SEL_W-1:0]         DST_SELECTION;
    logic [NUM_SRC*WIDTH-1:0] DST_IN;
    logic                     IN_VALID;
    logic                     IN_READY;
    logic [WIDTH-1:0]         DST_OUT;
    logic                     OUT_VALID;
    logic                     OUT_READY;
    logic                     SEL_ERR;
    logic                     ERR_CLR;
    logic [CNT_W-1:0]         XFER_CNT;

    modport master (
        output DST_SELECTION, DST_IN, IN_VALID, OUT_READY, ERR_CLR,
        input  IN_READY, DST_OUT, OUT_VALID, SEL_ERR, XFER_CNT
    );

    modport slave (
        input  DST_SELECTION, DST_IN, IN_VALID, OUT_READY, ERR_CLR,
        output IN_READY, DST_OUT, OUT_VALID, SEL_ERR, XFER_CNT
    );

endinterface

// File: rtl/dst_mux_pipe_skid_buf.sv
// Two-entry valid/ready skid buffer; ready depends only on registered occupancy.
module dst_skid_buf
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready_c,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid_c,
    input  logic             out_ready
);

    buf_state_e       state_q, state_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             accept_c;
    logic             pop_c;

    assign in_ready_c  = !rst && (state_q != BUF_FULL);
    assign out_valid_c = (state_q != BUF_EMPTY);
    assign accept_c    = in_valid && in_ready_c;
    assign pop_c       = out_valid_c && out_ready;
    assign out_data    = head_q;

    // Head always holds the oldest entry; skid only fills while head is stalled.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        case (state_q)
            BUF_EMPTY: begin
                if (accept_c) begin
                    state_d = BUF_ONE;
                    head_d  = in_data;
                end
            end
            BUF_ONE: begin
                if (accept_c && pop_c) begin
                    head_d = in_data;
                end else if (accept_c) begin
                    state_d = BUF_FULL;
                    skid_d  = in_data;
                end else if (pop_c) begin
                    state_d = BUF_EMPTY;
                end
            end
            BUF_FULL: begin
                if (pop_c) begin
                    state_d = BUF_ONE;
                    head_d  = skid_q;
                end
            end
            default: state_d = BUF_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BUF_EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: rtl/dst_mux_pipe.sv
// Registered destination multiplexer: source select, sticky range-error flag,
// transfer counter and a skid buffer towards the write port.
module dst_mux_pipe
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH   = DATA_W,
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned SEL_W   = $clog2(NUM_SRC),
    parameter int unsigned CNT_W   = 16
) (
    input  logic          CLK,
    input  logic          RST,
    dst_mux_pipe_if.slave bus
);

    localparam int unsigned            SELX_W    = SEL_W + 1;
    localparam logic [SELX_W-1:0]      NUM_SRC_X = SELX_W'(NUM_SRC);

    logic [WIDTH-1:0] sel_data_c;
    logic             sel_bad_c;
    logic             in_ready_c;
    logic             out_valid_c;
    logic             accept_c;
    logic             pop_c;
    logic [WIDTH-1:0] dst_out;
    logic             sel_err_q, sel_err_d;
    logic [CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;

    // Out-of-range indices fall back to source 0.
    always_comb begin
        sel_data_c = bus.DST_IN[0 +: WIDTH];
        sel_bad_c  = {1'b0, bus.DST_SELECTION} >= NUM_SRC_X;
        for (int k = 1; k < int'(NUM_SRC); k++) begin
            if (bus.DST_SELECTION == SEL_W'(k)) begin
                sel_data_c = bus.DST_IN[k*WIDTH +: WIDTH];
            end
        end
    end

    assign accept_c = bus.IN_VALID && in_ready_c;
    assign pop_c    = out_valid_c && bus.OUT_READY;

    // A new error wins over a simultaneous clear.
    always_comb begin
        sel_err_d = sel_err_q;
        if (accept_c && sel_bad_c) begin
            sel_err_d = 1'b1;
        end else if (bus.ERR_CLR) begin
            sel_err_d = 1'b0;
        end
        xfer_cnt_d = xfer_cnt_q + CNT_W'(pop_c);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sel_err_q  <= 1'b0;
            xfer_cnt_q <= '0;
        end else begin
            sel_err_q  <= sel_err_d;
            xfer_cnt_q <= xfer_cnt_d;
        end
    end

    dst_skid_buf #(
        .WIDTH (WIDTH)
    ) u_skid (
        .clk         (CLK),
        .rst         (RST),
        .in_data     (sel_data_c),
        .in_valid    (bus.IN_VALID),
        .in_ready_c  (in_ready_c),
        .out_data    (dst_out),
        .out_valid_c (out_valid_c),
        .out_ready   (bus.OUT_READY)
    );

    assign bus.IN_READY  = in_ready_c;
    assign bus.OUT_VALID = out_valid_c;
    assign bus.DST_OUT   = dst_out;
    assign bus.SEL_ERR   = sel_err_q;
    assign bus.XFER_CNT  = xfer_cnt_q;

endmodule

// File: tb/tb_dst_mux_pipe.sv
// Directed bench for dst_mux_pipe: default config, a 3-source/4-bit-counter
// config and a 32-bit/8-source config exercised against a FIFO scoreboard.
module tb_dst_mux_pipe;
    import cpu_pkg::*;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    dst_mux_pipe_if #(.WIDTH(16), .NUM_SRC(4), .CNT_W(16)) a_if ();
    dst_mux_pipe_if #(.WIDTH(16), .NUM_SRC(3), .CNT_W(4))  b_if ();
    dst_mux_pipe_if #(.WIDTH(32), .NUM_SRC(8), .CNT_W(16)) c_if ();

    dst_mux_pipe #(.WIDTH(16), .NUM_SRC(4), .CNT_W(16)) u_a (.CLK(clk), .RST(rst), .bus(a_if));
    dst_mux_pipe #(.WIDTH(16), .NUM_SRC(3), .CNT_W(4))  u_b (.CLK(clk), .RST(rst), .bus(b_if));
    dst_mux_pipe #(.WIDTH(32), .NUM_SRC(8), .CNT_W(16)) u_c (.CLK(clk), .RST(rst), .bus(c_if));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic        cv, cr, acc;
    logic [2:0]  cs;
    logic [31:0] cw [8];
    logic [31:0] sbq [$];
    int unsigned mcnt;

    initial begin
        errors = 0;
        checks = 0;
        mcnt   = 0;
        rst    = 1'b1;
        a_if.DST_SELECTION = '0; a_if.DST_IN = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        a_if.IN_VALID = 1'b1;    a_if.OUT_READY = 1'b1; a_if.ERR_CLR = 1'b0;
        b_if.DST_SELECTION = '0; b_if.DST_IN = {16'h5678, 16'h1234, 16'hABCD};
        b_if.IN_VALID = 1'b0;    b_if.OUT_READY = 1'b1; b_if.ERR_CLR = 1'b0;
        c_if.DST_SELECTION = '0; c_if.DST_IN = '0;
        c_if.IN_VALID = 1'b0;    c_if.OUT_READY = 1'b0; c_if.ERR_CLR = 1'b0;

        // Reset held two cycles with a pending request.
        tick();
        tick();
        chk("rst_in_ready",  a_if.IN_READY,  1'b0);
        chk("rst_out_valid", a_if.OUT_VALID, 1'b0);
        chk("rst_dst_out",   a_if.DST_OUT,   16'h0);
        chk("rst_xfer_cnt",  a_if.XFER_CNT,  16'h0);
        chk("rst_sel_err",   a_if.SEL_ERR,   1'b0);
        rst = 1'b0;
        a_if.IN_VALID = 1'b0;
        #1;
        chk("post_rst_in_ready", a_if.IN_READY, 1'b1);
        tick();
        chk("post_rst_idle", a_if.OUT_VALID, 1'b0);

        // Streaming, one transfer per cycle.
        a_if.IN_VALID = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_if.DST_SELECTION = 2'(i);
            #1;
            chk("stream_in_ready", a_if.IN_READY, 1'b1);
            tick();
            chk("stream_valid", a_if.OUT_VALID, 1'b1);
            chk("stream_data",  a_if.DST_OUT,   {4{4'(i + 1)}});
        end
        a_if.IN_VALID = 1'b0;
        tick();
        chk("stream_cnt",   a_if.XFER_CNT,  16'd4);
        chk("stream_empty", a_if.OUT_VALID, 1'b0);
        chk("stream_hold",  a_if.DST_OUT,   16'h4444);

        // Backpressure fills both entries.
        a_if.OUT_READY = 1'b0;
        a_if.IN_VALID  = 1'b1;
        a_if.DST_SELECTION = 2'(DST_C);
        tick();
        chk("bp_one_data", a_if.DST_OUT, 16'h3333);
        a_if.DST_SELECTION = 2'(DST_D);
        tick();
        chk("bp_full_ready", a_if.IN_READY,  1'b0);
        chk("bp_full_data",  a_if.DST_OUT,   16'h3333);
        chk("bp_full_valid", a_if.OUT_VALID, 1'b1);
        a_if.IN_VALID = 1'b0;
        a_if.DST_SELECTION = 2'(DST_A);
        tick();
        chk("bp_stable_data", a_if.DST_OUT,  16'h3333);
        chk("bp_stable_cnt",  a_if.XFER_CNT, 16'd4);
        a_if.OUT_READY = 1'b1;
        tick();
        chk("bp_pop1_data",  a_if.DST_OUT,  16'h4444);
        chk("bp_pop1_ready", a_if.IN_READY, 1'b1);
        chk("bp_pop1_cnt",   a_if.XFER_CNT, 16'd5);
        tick();
        chk("bp_pop2_valid", a_if.OUT_VALID, 1'b0);
        chk("bp_pop2_cnt",   a_if.XFER_CNT,  16'd6);

        // Out-of-range selection on the 3-source instance.
        b_if.DST_SELECTION = 2'd3;
        b_if.IN_VALID = 1'b0;
        tick();
        chk("oor_no_accept", b_if.SEL_ERR, 1'b0);
        b_if.IN_VALID = 1'b1;
        tick();
        chk("oor_data",    b_if.DST_OUT, 16'hABCD);
        chk("oor_err_set", b_if.SEL_ERR, 1'b1);
        b_if.DST_SELECTION = 2'd2;
        tick();
        chk("oor_good_data", b_if.DST_OUT, 16'h5678);
        chk("oor_sticky",    b_if.SEL_ERR, 1'b1);
        b_if.DST_SELECTION = 2'd3;
        b_if.ERR_CLR = 1'b1;
        tick();
        chk("oor_set_beats_clr", b_if.SEL_ERR, 1'b1);
        chk("oor_data2",         b_if.DST_OUT, 16'hABCD);
        b_if.IN_VALID = 1'b0;
        tick();
        chk("oor_clr", b_if.SEL_ERR, 1'b0);
        b_if.ERR_CLR = 1'b0;
        chk("oor_cnt", b_if.XFER_CNT, 4'd3);

        // Counter wrap on the 4-bit counter.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        b_if.DST_SELECTION = 2'd1;
        b_if.IN_VALID = 1'b1;
        for (int i = 0; i < 17; i++) tick();
        chk("wrap_16_pops", b_if.XFER_CNT, 4'd0);
        chk("wrap_data",    b_if.DST_OUT,  16'h1234);
        b_if.IN_VALID = 1'b0;
        tick();
        chk("wrap_17_pops", b_if.XFER_CNT, 4'd1);

        // Reset while full discards buffered data.
        b_if.OUT_READY = 1'b0;
        b_if.IN_VALID  = 1'b1;
        b_if.DST_SELECTION = 2'd0;
        tick();
        b_if.DST_SELECTION = 2'd1;
        tick();
        chk("mid_full_ready", b_if.IN_READY, 1'b0);
        rst = 1'b1;
        b_if.OUT_READY = 1'b1;
        tick();
        chk("mid_rst_valid", b_if.OUT_VALID, 1'b0);
        chk("mid_rst_data",  b_if.DST_OUT,   16'h0);
        chk("mid_rst_cnt",   b_if.XFER_CNT,  4'd0);
        chk("mid_rst_ready", b_if.IN_READY,  1'b0);
        rst = 1'b0;
        b_if.IN_VALID = 1'b0;
        tick();
        chk("mid_rst_lost", b_if.OUT_VALID, 1'b0);

        // Random valid/ready on the 32-bit, 8-source instance.
        for (int n = 0; n < 304; n++) begin
            cv = (n < 300) ? ($urandom_range(0, 9) < 7) : 1'b0;
            cr = (n < 300) ? ($urandom_range(0, 9) < 6) : 1'b1;
            cs = 3'($urandom_range(0, 7));
            for (int k = 0; k < 8; k++) begin
                cw[k] = $urandom;
                c_if.DST_IN[k*32 +: 32] = cw[k];
            end
            c_if.IN_VALID  = cv;
            c_if.OUT_READY = cr;
            c_if.DST_SELECTION = cs;
            #1;
            chk("rnd_in_ready",  c_if.IN_READY,  sbq.size() < 2);
            chk("rnd_out_valid", c_if.OUT_VALID, sbq.size() != 0);
            acc = cv && (sbq.size() < 2);
            if (cr && sbq.size() != 0) begin
                chk("rnd_data", c_if.DST_OUT, sbq[0]);
                void'(sbq.pop_front());
                mcnt++;
            end
            if (acc) sbq.push_back(cw[cs]);
            tick();
        end
        chk("rnd_cnt",     c_if.XFER_CNT,  16'(mcnt));
        chk("rnd_drained", c_if.OUT_VALID, 1'b0);
        chk("rnd_no_err",  c_if.SEL_ERR,   1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dst_mux_pipe.md
Name: dst_mux_pipe

Overview:
- Parametrised, registered successor to the CPU's 4-way 16-bit destination multiplexer.
- Selects one of NUM_SRC WIDTH-bit sources per transfer and buffers the result in a 2-entry skid buffer with a valid/ready handshake, so the datapath can stall without losing results.
- Flags out-of-range selections and counts completed transfers for debug.
- Sits between the source operand/result buses and the register-file/memory write port.

Parameters:
- WIDTH, 16, data width of each source and of DST_OUT
- NUM_SRC, 4, number of sources (2..16)
- SEL_W, $clog2(NUM_SRC), selection width (derived; do not override)
- CNT_W, 16, width of transfer counter

Ports:
- CLK  in  1  clock, all state updates on rising edge
- RST  in  1  reset, synchronous, active-high
- DST_SELECTION  in  SEL_W  source index, sampled on accept
- DST_IN  in  NUM_SRC*WIDTH  flattened sources; source k = bits [k*WIDTH +: WIDTH]
- IN_VALID  in  1  upstream has a transfer
- IN_READY  out  1  block can accept
- DST_OUT  out  WIDTH  head-of-buffer data
- OUT_VALID  out  1  DST_OUT valid
- OUT_READY  in  1  downstream consumes
- SEL_ERR  out  1  sticky: an out-of-range selection was accepted
- ERR_CLR  in  1  clears SEL_ERR
- XFER_CNT  out  CNT_W  number of output handshakes completed

Behaviour:
- Handshake rules:
  - accept = IN_VALID & IN_READY.
  - pop = OUT_VALID & OUT_READY.
- Reset, while RST=1 at a clock edge:
  - count=0, OUT_VALID=0, DST_OUT=0, skid reg=0, SEL_ERR=0, XFER_CNT=0.
  - IN_READY is forced 0 while RST is high.
  - RST overrides every simultaneous event; data in flight is discarded.
- Selection:
  - Selected data = DST_IN source DST_SELECTION.
  - If DST_SELECTION >= NUM_SRC (only possible when NUM_SRC is not a power of 2), source 0 is taken and SEL_ERR sets on accept.
- Buffer states, 2-bit count: EMPTY(0), ONE(1), FULL(2).
  - IN_READY = !RST & (count != FULL), derived from registered count only; no combinational path from OUT_READY.
  - OUT_VALID = (count != EMPTY).
  - Latency: accept in cycle N gives OUT_VALID=1 with data in cycle N+1.
- Transitions:
  - EMPTY + accept -> ONE, head <= selected data.
  - ONE + accept, no pop -> FULL, skid <= selected data.
  - ONE + pop, no accept -> EMPTY; DST_OUT holds its last value (not zeroed).
  - ONE + accept + pop -> ONE, head <= selected data. This is the full-throughput case: 1 transfer per cycle.
  - FULL + pop -> ONE, head <= skid. No accept is possible since IN_READY=0.
  - No event -> hold all state.
- Stability: while OUT_VALID=1 and OUT_READY=0, DST_OUT and OUT_VALID stay stable.
- Ordering: strictly FIFO.
- SEL_ERR: set has priority over ERR_CLR in the same cycle; otherwise ERR_CLR clears it next edge.
- XFER_CNT: increments by 1 per pop and wraps modulo 2^CNT_W (all-ones -> 0).
- No X propagation: unselected or invalid inputs must not affect outputs when accept=0.

Decomposition:
- Shared package cpu_pkg:
  - DATA_W=16 default and the DST_* source index constants (DST_A=0 .. DST_D=3).
  - localparam enum for buffer states (BUF_EMPTY/BUF_ONE/BUF_FULL).
- One natural sub-module: dst_skid_buf (WIDTH-generic 2-entry valid/ready buffer, no selection logic). dst_mux_pipe = combinational select + error flag + counter + dst_skid_buf.

Test Plan:
- Reset: RST=1 for 2 cycles with IN_VALID=1 -> IN_READY=0, OUT_VALID=0, DST_OUT=0, XFER_CNT=0; IN_READY=1 on first cycle after RST drops.
- Streaming: sources {0x1111,0x2222,0x3333,0x4444}, SEL 0,1,2,3 on consecutive cycles, OUT_READY=1 -> DST_OUT 0x1111..0x4444 on cycles 1..4, IN_READY never drops, XFER_CNT=4.
- Backpressure: OUT_READY=0, push SEL=2 then SEL=3 -> count FULL, IN_READY=0, DST_OUT=0x3333 held; raise OUT_READY -> 0x3333 then 0x4444, IN_READY=1 after first pop.
- Out-of-range: NUM_SRC=3, SEL=3 with source0=0xABCD -> DST_OUT=0xABCD, SEL_ERR=1 sticky; ERR_CLR=1 together with another bad accept -> stays 1; ERR_CLR alone -> 0.
- Wrap and mid-op reset: CNT_W=4, 17 pops -> XFER_CNT=1; assert RST while FULL -> next cycle count=0, OUT_VALID=0, buffered data lost.
- Parameter sweep: WIDTH=8/32, NUM_SRC=2/8, randomised valid/ready vs. scoreboard -> no loss, duplication or reordering.
